// File: rtl/pat_buf_pkg.sv
// Shared widths, field offsets and read-tag types for the pattern-buffer access path.
package pat_buf_pkg;

  localparam int NUM_FIELDS  = 22;
  localparam int BUF_IDX_W   = 3;
  localparam int FIELD_IDX_W = 5;
  localparam int BYTE_W      = 8;

  typedef enum logic [FIELD_IDX_W-1:0] {
    PDRIVE  = 5'd0,  NDRIVE  = 5'd1,  PODT    = 5'd2,  NODT    = 5'd3,
    PSLEW   = 5'd4,  NSLEW   = 5'd5,
    PTWEAK0 = 5'd6,  PTWEAK1 = 5'd7,  PTWEAK2 = 5'd8,  PTWEAK3 = 5'd9,
    PTWEAK4 = 5'd10, PTWEAK5 = 5'd11, PTWEAK6 = 5'd12, PTWEAK7 = 5'd13,
    NTWEAK0 = 5'd14, NTWEAK1 = 5'd15, NTWEAK2 = 5'd16, NTWEAK3 = 5'd17,
    NTWEAK4 = 5'd18, NTWEAK5 = 5'd19, NTWEAK6 = 5'd20, NTWEAK7 = 5'd21
  } field_e;

  typedef enum logic { OWN_A = 1'b0, OWN_B = 1'b1 } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

  function automatic logic field_ok(input logic [FIELD_IDX_W-1:0] field);
    return 32'(field) < NUM_FIELDS;
  endfunction

endpackage

// File: rtl/pb_rd_tag_pipe.sv
// Delay line that carries a read's {valid, owner, err} tag alongside the buffer read latency.
module pb_rd_tag_pipe
  import pat_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage [DEPTH];

  // NOTE: the tag pipe is cleared on reset so an aborted read can never surface as rvalid later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/patbuf_access_arbiter.sv
// Shares the pattern-buffer field port between the pat core (A, priority) and host loader (B),
// never moving bufp and the field pointer in the same cycle, and routing read data back to its owner.
module patbuf_access_arbiter
  import pat_buf_pkg::*;
#(
  parameter int READ_LAT    = 2,
  parameter int A_BURST_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [BUF_IDX_W-1:0]   a_buf,
  input  logic [FIELD_IDX_W-1:0] a_field,
  input  logic [BYTE_W-1:0]      a_wdata,
  output logic                   a_gnt,
  output logic                   a_rvalid,
  output logic [BYTE_W-1:0]      a_rdata,
  output logic                   a_err,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [BUF_IDX_W-1:0]   b_buf,
  input  logic [FIELD_IDX_W-1:0] b_field,
  input  logic [BYTE_W-1:0]      b_wdata,
  output logic                   b_gnt,
  output logic                   b_rvalid,
  output logic [BYTE_W-1:0]      b_rdata,
  output logic                   b_err,
  output logic [BUF_IDX_W-1:0]   bufp_out,
  output logic [FIELD_IDX_W-1:0] fieldp_out,
  output logic [FIELD_IDX_W-1:0] fieldwp_out,
  output logic [BYTE_W-1:0]      field_out,
  output logic                   field_write_out,
  input  logic [BYTE_W-1:0]      field_byte_in
);

  localparam int STREAK_W = $clog2(A_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(A_BURST_MAX);

  typedef enum logic { IDLE = 1'b0, ALIGN = 1'b1 } state_e;

  state_e                 state, state_next;
  logic [STREAK_W-1:0]    streak;
  logic                   a_win, granted, need_align, do_issue;
  logic                   sel_we, sel_ok, iss_we, pend_we;
  owner_e                 sel_owner, iss_owner, pend_owner;
  logic [BUF_IDX_W-1:0]   sel_buf;
  logic [FIELD_IDX_W-1:0] sel_field, iss_field, pend_field;
  logic [BYTE_W-1:0]      sel_wdata, iss_wdata, pend_wdata;
  rd_tag_t                iss_tag, ret_tag;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    a_win      = a_req && !(b_req && streak == STREAK_MAX);
    sel_owner  = a_win ? OWN_A : OWN_B;
    sel_we     = a_win ? a_we : b_we;
    sel_buf    = a_win ? a_buf : b_buf;
    sel_field  = a_win ? a_field : b_field;
    sel_wdata  = a_win ? a_wdata : b_wdata;
    sel_ok     = field_ok(sel_field);
    need_align = sel_ok && (sel_buf != bufp_out) &&
                 (sel_field != (sel_we ? fieldwp_out : fieldp_out));

    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    state_next = state;
    if (state == IDLE && !reset) begin
      a_gnt = a_win;
      b_gnt = b_req && !a_win;
    end
    granted = a_gnt || b_gnt;

    if (granted && need_align) state_next = ALIGN;
    else if (state == ALIGN)   state_next = IDLE;

    // The pointer moves either right after an aligned-free grant or out of the ALIGN cycle.
    do_issue  = (granted && sel_ok && !need_align) || (state == ALIGN);
    iss_we    = (state == ALIGN) ? pend_we    : sel_we;
    iss_owner = (state == ALIGN) ? pend_owner : sel_owner;
    iss_field = (state == ALIGN) ? pend_field : sel_field;
    iss_wdata = (state == ALIGN) ? pend_wdata : sel_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      streak          <= '0;
      bufp_out        <= '0;
      fieldp_out      <= '0;
      fieldwp_out     <= '0;
      field_out       <= '0;
      field_write_out <= 1'b0;
      a_err           <= 1'b0;
      b_err           <= 1'b0;
      iss_tag         <= '0;
      pend_we         <= 1'b0;
      pend_owner      <= OWN_A;
      pend_field      <= '0;
      pend_wdata      <= '0;
    end else begin
      state           <= state_next;
      field_write_out <= 1'b0;
      a_err           <= 1'b0;
      b_err           <= 1'b0;
      iss_tag         <= '0;

      if (!b_req || b_gnt)                  streak <= '0;
      else if (a_gnt && streak != STREAK_MAX) streak <= streak + 1'b1;

      if (granted && sel_ok) bufp_out <= sel_buf;

      if (granted && need_align) begin
        pend_we    <= sel_we;
        pend_owner <= sel_owner;
        pend_field <= sel_field;
        pend_wdata <= sel_wdata;
      end

      if (granted && !sel_ok) begin
        a_err   <= (sel_owner == OWN_A);
        b_err   <= (sel_owner == OWN_B);
        iss_tag <= '{valid: !sel_we, owner: sel_owner, err: 1'b1};
      end

      if (do_issue) begin
        if (iss_we) begin
          fieldwp_out     <= iss_field;
          field_out       <= iss_wdata;
          field_write_out <= 1'b1;
        end else begin
          fieldp_out <= iss_field;
          iss_tag    <= '{valid: 1'b1, owner: iss_owner, err: 1'b0};
        end
      end
    end
  end

  pb_rd_tag_pipe #(.DEPTH(READ_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (iss_tag),
    .tag_out (ret_tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= ret_tag.valid && (ret_tag.owner == OWN_A);
      b_rvalid <= ret_tag.valid && (ret_tag.owner == OWN_B);
      a_rdata  <= (ret_tag.valid && ret_tag.owner == OWN_A && !ret_tag.err) ? field_byte_in : '0;
      b_rdata  <= (ret_tag.valid && ret_tag.owner == OWN_B && !ret_tag.err) ? field_byte_in : '0;
    end
  end

endmodule

// File: tb/tb_patbuf_access_arbiter.sv
// Randomized bench for patbuf_access_arbiter against a transaction-level scheduling model.
module tb_patbuf_access_arbiter;
  import pat_buf_pkg::*;

  localparam int READ_LAT    = 2;
  localparam int A_BURST_MAX = 4;
  localparam int RING        = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic a_req, a_we, b_req, b_we;
  logic [BUF_IDX_W-1:0]   a_buf, b_buf, bufp_out;
  logic [FIELD_IDX_W-1:0] a_field, b_field, fieldp_out, fieldwp_out;
  logic [BYTE_W-1:0]      a_wdata, b_wdata, a_rdata, b_rdata, field_out, field_byte_in;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, field_write_out;

  always #5 clk = ~clk;

  patbuf_access_arbiter #(.READ_LAT(READ_LAT), .A_BURST_MAX(A_BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_buf(a_buf), .a_field(a_field), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_buf(b_buf), .b_field(b_field), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .bufp_out(bufp_out), .fieldp_out(fieldp_out), .fieldwp_out(fieldwp_out),
    .field_out(field_out), .field_write_out(field_write_out), .field_byte_in(field_byte_in)
  );

  typedef struct {
    logic       we;
    logic [2:0] bi;
    logic [4:0] fi;
    logic [7:0] wd;
    int         gap;
  } txn_t;

  txn_t q_a[$], q_b[$];
  txn_t cur [2];
  logic act [2];
  int   gap_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected pointers plus a ring of events scheduled by absolute cycle.
  int         cyc;
  int         m_streak;
  logic [2:0] m_bufp;
  logic [4:0] m_fieldp, m_fieldwp;
  logic       r_busy [RING];
  logic       r_setb_v [RING], r_setfp_v [RING], r_setfw_v [RING], r_wr [RING];
  logic [2:0] r_setb [RING];
  logic [4:0] r_setfp [RING], r_setfw [RING];
  logic [7:0] r_wdata [RING];
  logic       r_rv [2][RING], r_err [2][RING];
  logic [7:0] r_rd [2][RING];
  logic [7:0] hist [READ_LAT];

  function automatic logic [7:0] pb_data(input int b, input int f);
    return 8'((b * 37 + f * 11 + 57) & 255);
  endfunction

  function automatic txn_t mk(input logic we, input int b, input int f, input int d, input int gap);
    txn_t t;
    t.we = we; t.bi = 3'(b); t.fi = 5'(f); t.wd = 8'(d); t.gap = gap;
    return t;
  endfunction

  task automatic clear_slot(input int s);
    r_busy[s] = 0; r_setb_v[s] = 0; r_setfp_v[s] = 0; r_setfw_v[s] = 0; r_wr[s] = 0;
    r_setb[s] = 0; r_setfp[s] = 0; r_setfw[s] = 0; r_wdata[s] = 0;
    for (int o = 0; o < 2; o++) begin
      r_rv[o][s] = 0; r_err[o][s] = 0; r_rd[o][s] = 0;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < RING; s++) clear_slot(s);
    for (int i = 0; i < READ_LAT; i++) hist[i] = pb_data(0, 0);
    m_streak = 0; m_bufp = 0; m_fieldp = 0; m_fieldwp = 0;
    q_a.delete(); q_b.delete();
    for (int o = 0; o < 2; o++) begin
      act[o] = 0; gap_cnt[o] = 0;
    end
  endtask

  task automatic step();
    int s, o, issue;
    logic g [2];
    logic align;
    txn_t t;
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % RING;
    if (r_setb_v[s])  m_bufp    = r_setb[s];
    if (r_setfp_v[s]) m_fieldp  = r_setfp[s];
    if (r_setfw_v[s]) m_fieldwp = r_setfw[s];
    field_byte_in = hist[READ_LAT-1];

    for (int k = 0; k < 2; k++) begin
      if (!act[k]) begin
        if (gap_cnt[k] > 0) gap_cnt[k]--;
        else if (k == 0 && q_a.size() != 0) begin cur[0] = q_a.pop_front(); act[0] = 1; end
        else if (k == 1 && q_b.size() != 0) begin cur[1] = q_b.pop_front(); act[1] = 1; end
      end
    end
    a_req   = act[0];
    a_we    = act[0] ? cur[0].we : 1'($urandom);
    a_buf   = act[0] ? cur[0].bi : 3'($urandom);
    a_field = act[0] ? cur[0].fi : 5'($urandom);
    a_wdata = act[0] ? cur[0].wd : 8'($urandom);
    b_req   = act[1];
    b_we    = act[1] ? cur[1].we : 1'($urandom);
    b_buf   = act[1] ? cur[1].bi : 3'($urandom);
    b_field = act[1] ? cur[1].fi : 5'($urandom);
    b_wdata = act[1] ? cur[1].wd : 8'($urandom);

    g[0] = 0; g[1] = 0;
    if (!r_busy[s]) begin
      if (act[0] && !(act[1] && m_streak == A_BURST_MAX)) g[0] = 1;
      else if (act[1]) g[1] = 1;
    end

    @(negedge clk);
    check("a_gnt", a_gnt, g[0]);
    check("b_gnt", b_gnt, g[1]);
    check("a_err", a_err, r_err[0][s]);
    check("b_err", b_err, r_err[1][s]);
    check("a_rvalid", a_rvalid, r_rv[0][s]);
    check("b_rvalid", b_rvalid, r_rv[1][s]);
    check("a_rdata", a_rdata, r_rd[0][s]);
    check("b_rdata", b_rdata, r_rd[1][s]);
    check("bufp_out", bufp_out, m_bufp);
    check("fieldp_out", fieldp_out, m_fieldp);
    check("fieldwp_out", fieldwp_out, m_fieldwp);
    check("field_write_out", field_write_out, r_wr[s]);
    if (r_wr[s]) check("field_out", field_out, r_wdata[s]);
    clear_slot(s);

    if (!act[1] || g[1]) m_streak = 0;
    else if (g[0] && m_streak < A_BURST_MAX) m_streak++;

    if (g[0] || g[1]) begin
      o = g[0] ? 0 : 1;
      t = cur[o];
      if (int'(t.fi) >= NUM_FIELDS) begin
        r_err[o][(cyc + 1) % RING] = 1;
        if (!t.we) begin
          r_rv[o][(cyc + 2 + READ_LAT) % RING] = 1;
          r_rd[o][(cyc + 2 + READ_LAT) % RING] = 0;
        end
      end else begin
        align = (t.bi != m_bufp) && (t.fi != (t.we ? m_fieldwp : m_fieldp));
        issue = cyc + (align ? 2 : 1);
        r_setb_v[(cyc + 1) % RING] = 1;
        r_setb[(cyc + 1) % RING]   = t.bi;
        if (align) r_busy[(cyc + 1) % RING] = 1;
        if (t.we) begin
          r_setfw_v[issue % RING] = 1;
          r_setfw[issue % RING]   = t.fi;
          r_wr[issue % RING]      = 1;
          r_wdata[issue % RING]   = t.wd;
        end else begin
          r_setfp_v[issue % RING] = 1;
          r_setfp[issue % RING]   = t.fi;
          r_rv[o][(issue + READ_LAT + 1) % RING] = 1;
          r_rd[o][(issue + READ_LAT + 1) % RING] = pb_data(int'(t.bi), int'(t.fi));
        end
      end
    end

    if (a_gnt) begin act[0] = 0; gap_cnt[0] = cur[0].gap; end
    if (b_gnt) begin act[1] = 0; gap_cnt[1] = cur[1].gap; end

    for (int i = READ_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pb_data(int'(bufp_out), int'(fieldp_out));
  endtask

  task automatic apply_reset(input int hold);
    #2;
    a_req = 1; b_req = 1;
    reset = 1;
    #1;
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_a_err", a_err, 0);
    check("rst_b_err", b_err, 0);
    check("rst_bufp", bufp_out, 0);
    check("rst_fieldp", fieldp_out, 0);
    check("rst_fieldwp", fieldwp_out, 0);
    check("rst_field_out", field_out, 0);
    check("rst_field_write", field_write_out, 0);
    a_req = 0; b_req = 0;
    model_clear();
    repeat (hold) @(negedge clk);
    reset = 0;
  endtask

  task automatic run_drain(input int limit);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || act[0] || act[1]) && n < limit) begin
      step();
      n++;
    end
    check("drain_in_budget", n < limit, 1);
    repeat (READ_LAT + 4) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc = 0;
    a_req = 0; a_we = 0; a_buf = 0; a_field = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_buf = 0; b_field = 0; b_wdata = 0;
    field_byte_in = 0;
    model_clear();
    #1;
    apply_reset(2);

    // Read right after reset: buf 0 field 3 returns 0x5A, no align.
    q_a.push_back(mk(0, 0, 3, 0, 0));
    run_drain(50);

    // Host write forcing the one-cycle bufp-only align step.
    q_b.push_back(mk(1, 5, 7, 8'hC3, 0));
    run_drain(50);

    // Both requesters saturated: A,A,A,A,B pattern.
    for (int i = 0; i < 12; i++) q_a.push_back(mk(0, $urandom_range(0, 1), $urandom_range(0, 21), 0, 0));
    for (int i = 0; i < 3; i++)  q_b.push_back(mk(0, $urandom_range(0, 1), $urandom_range(0, 21), 0, 0));
    run_drain(200);

    // Out-of-range field: err pulse, zero data, no pointer or write activity.
    q_a.push_back(mk(0, 3, 22, 0, 0));
    q_b.push_back(mk(1, 6, 31, 8'hEE, 0));
    run_drain(50);

    // Four back-to-back reads on the current buffer.
    for (int f = 1; f <= 4; f++) q_a.push_back(mk(0, int'(m_bufp), f, 0, 0));
    run_drain(50);

    // Reset with two reads in flight, then a normal access.
    q_a.push_back(mk(0, int'(m_bufp), 9, 0, 0));
    q_a.push_back(mk(0, int'(m_bufp), 10, 0, 0));
    n = 0;
    while ((q_a.size() != 0 || act[0]) && n < 20) begin
      step();
      n++;
    end
    check("inflight_grants", n < 20, 1);
    step();
    apply_reset(2);
    repeat (READ_LAT + 3) step();
    q_a.push_back(mk(0, 2, 5, 0, 0));
    run_drain(50);

    // Random traffic from both requesters.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0)
        q_a.push_back(mk(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 25),
                         $urandom, $urandom_range(0, 3)));
      else
        q_b.push_back(mk(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 25),
                         $urandom, $urandom_range(0, 2)));
    end
    run_drain(5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
